// File: rtl/fft_frame_ctrl_if.sv
// Bus bundle for fft_frame_ctrl: sample source, first-stage feed, last-stage results and indexed output stream.
// The slave modport is the controller's view; master is the environment's view.
interface fft_frame_ctrl_if #(
    parameter int TOTAL_STAGE = 8,
    parameter int CPLX_WIDTH  = 32
);
    logic                   s_valid;
    logic [CPLX_WIDTH-1:0]  s_data;
    logic                   s_ready;

    logic                   fft_en;
    logic [TOTAL_STAGE-1:0] fft_addr;
    logic [CPLX_WIDTH-1:0]  fft_data;

    logic                   res_en;
    logic [CPLX_WIDTH-1:0]  res_data;

    logic                   m_valid;
    logic [CPLX_WIDTH-1:0]  m_data;
    logic [TOTAL_STAGE-1:0] m_index;

    modport master (
        output s_valid, s_data, res_en, res_data,
        input  s_ready, fft_en, fft_addr, fft_data, m_valid, m_data, m_index
    );

    modport slave (
        input  s_valid, s_data, res_en, res_data,
        output s_ready, fft_en, fft_addr, fft_data, m_valid, m_data, m_index
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a streaming FFT: feeds gap-free N-sample frames into the first stage,
// tags last-stage results with their bin index, and tracks frames still in flight.
module fft_frame_ctrl #(
    parameter int TOTAL_STAGE = 8,
    parameter int CPLX_WIDTH  = 32,
    parameter int DRAIN_MAX   = 1024
) (
    input  logic              iclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              err_clr,
    output logic              busy,
    output logic              frame_done,
    output logic              err_underrun,
    output logic              err_timeout,
    fft_frame_ctrl_if.slave   bus
);

    localparam int                     DW         = $clog2(DRAIN_MAX + 1);
    localparam logic [TOTAL_STAGE-1:0] LAST_BIN   = '1;
    localparam logic [DW-1:0]          DRAIN_LAST = DW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [TOTAL_STAGE-1:0] in_cnt_q;
    logic [TOTAL_STAGE-1:0] out_cnt_q;
    logic [DW-1:0]          drain_cnt_q;
    logic [3:0]             outst_q;
    logic [3:0]             outst_d;

    logic                   fft_en_q;
    logic [TOTAL_STAGE-1:0] fft_addr_q;
    logic [CPLX_WIDTH-1:0]  fft_data_q;
    logic                   m_valid_q;
    logic [CPLX_WIDTH-1:0]  m_data_q;
    logic [TOTAL_STAGE-1:0] m_index_q;
    logic                   frame_done_q;
    logic                   err_under_q;
    logic                   err_to_q;

    logic                   frame_issued;
    logic                   drain_timeout;

    assign frame_issued  = (state_q == FEED)  && (in_cnt_q == LAST_BIN);
    assign drain_timeout = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);

    // Outstanding frames: issued but not yet seen complete on the result side.
    always_comb begin
        outst_d = outst_q;
        if (drain_timeout) begin
            outst_d = 4'd0;
        end else if (frame_issued && !frame_done_q) begin
            if (outst_q != 4'hF) outst_d = outst_q + 4'd1;
        end else if (!frame_issued && frame_done_q) begin
            if (outst_q != 4'd0) outst_d = outst_q - 4'd1;
        end
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            drain_cnt_q <= '0;
            outst_q     <= 4'd0;
            fft_en_q    <= 1'b0;
            fft_addr_q  <= '1;
            fft_data_q  <= '0;
            err_under_q <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            outst_q     <= outst_d;
            fft_en_q    <= 1'b0;
            fft_addr_q  <= '1;
            fft_data_q  <= '0;
            err_under_q <= (err_under_q && !err_clr) || ((state_q == FEED) && !bus.s_valid);
            err_to_q    <= (err_to_q && !err_clr) || drain_timeout;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FEED;
                        in_cnt_q <= '0;
                    end
                end
                FEED: begin
                    // A missing sample is replaced by zero so downstream stages never see a gap.
                    fft_en_q    <= 1'b1;
                    fft_addr_q  <= in_cnt_q;
                    fft_data_q  <= bus.s_valid ? bus.s_data : '0;
                    in_cnt_q    <= in_cnt_q + 1'b1;
                    drain_cnt_q <= '0;
                    if (frame_issued && !cont) state_q <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    if (drain_timeout) begin
                        state_q <= IDLE;
                    end else if ((out_cnt_q == '0) && (outst_q == 4'd0)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result path runs in every state so late results are never dropped.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_index_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            m_valid_q    <= bus.res_en;
            frame_done_q <= bus.res_en && (out_cnt_q == LAST_BIN);
            if (bus.res_en) begin
                m_data_q  <= bus.res_data;
                m_index_q <= out_cnt_q;
                out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign err_underrun = err_under_q;
    assign err_timeout  = err_to_q;

    assign bus.s_ready  = (state_q == FEED);
    assign bus.fft_en   = fft_en_q;
    assign bus.fft_addr = fft_addr_q;
    assign bus.fft_data = fft_data_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_index  = m_index_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with N=8: a vector table for single-shot frames and underrun,
// plus hand sequences for continuous mode, drain timeout and mid-frame reset.
module tb_fft_frame_ctrl;

    localparam int TS = 3;
    localparam int CW = 32;

    logic iclk = 1'b0;
    logic rst_n;
    logic start, cont, err_clr;
    logic busy, frame_done, err_underrun, err_timeout;

    int checks   = 0;
    int failures = 0;

    fft_frame_ctrl_if #(.TOTAL_STAGE(TS), .CPLX_WIDTH(CW)) ifc ();

    fft_frame_ctrl #(.TOTAL_STAGE(TS), .CPLX_WIDTH(CW), .DRAIN_MAX(16)) dut (
        .iclk         (iclk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .err_clr      (err_clr),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_underrun (err_underrun),
        .err_timeout  (err_timeout),
        .bus          (ifc.slave)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic        start;
        logic        cont;
        logic        s_valid;
        logic [31:0] s_data;
        logic        res_en;
        logic [31:0] res_data;
        logic        err_clr;
        logic        e_fen;
        logic [2:0]  e_addr;
        logic [31:0] e_fdata;
        logic        e_mv;
        logic [31:0] e_md;
        logic [2:0]  e_mi;
        logic        e_fd;
        logic        e_busy;
        logic        e_sready;
        logic        e_under;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sv, input logic [31:0] sd,
                       input logic re, input logic [31:0] rd, input logic clr,
                       input logic fen, input logic [2:0] addr, input logic [31:0] fdata,
                       input logic mv, input logic [31:0] md, input logic [2:0] mi,
                       input logic fd, input logic bsy, input logic srdy, input logic und);
        vec_t v;
        v.start = st;   v.cont = 1'b0; v.s_valid = sv; v.s_data = sd;
        v.res_en = re;  v.res_data = rd; v.err_clr = clr;
        v.e_fen = fen;  v.e_addr = addr; v.e_fdata = fdata;
        v.e_mv = mv;    v.e_md = md; v.e_mi = mi; v.e_fd = fd;
        v.e_busy = bsy; v.e_sready = srdy; v.e_under = und;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; cont = 1'b0; err_clr = 1'b0;
        ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.res_en = 1'b0; ifc.res_data = '0;
    endtask

    initial begin
        int exit_c;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_fft_en", ifc.fft_en, 0);
        chk("rst_fft_addr", ifc.fft_addr, 3'h7);
        chk("rst_fft_data", ifc.fft_data, 0);
        chk("rst_m_valid", ifc.m_valid, 0);
        chk("rst_m_index", ifc.m_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", ifc.s_ready, 0);
        chk("rst_errs", {err_underrun, err_timeout, frame_done}, 0);
        rst_n = 1'b1;

        // Table A: single frame of samples 1..8, then 8 results 0x10..0x17, then back to IDLE.
        add(1, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  1, 1, 0);
        for (int j = 1; j <= 8; j++)
            add(0, 1, j, 0, 0, 0,  1, 3'(j - 1), j,  0, 0, 0, 0,  1, (j < 8), 0);
        for (int k = 0; k < 8; k++)
            add(0, 0, 0, 1, 32'h10 + k, 0,  0, 3'd7, 0,  1, 32'h10 + k, 3'(k), (k == 7),  1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  0, 0, 0);

        // Table B: sample at address 3 missing -> zero issued, sticky underrun until err_clr.
        add(1, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  1, 1, 0);
        for (int j = 1; j <= 8; j++)
            add(0, (j != 4), (j == 4) ? 32'hDEAD : 32'h100 + j, 0, 0, 0,
                1, 3'(j - 1), (j == 4) ? 32'h0 : 32'h100 + j,  0, 0, 0, 0,  1, (j < 8), (j >= 4));
        for (int k = 0; k < 8; k++)
            add(0, 0, 0, 1, 32'h20 + k, 0,  0, 3'd7, 0,  1, 32'h20 + k, 3'(k), (k == 7),  1, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  1, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, 3'd7, 0,  0, 0, 0, 0,  0, 0, 1);
        add(0, 0, 0, 0, 0, 1,  0, 3'd7, 0,  0, 0, 0, 0,  0, 0, 0);

        step();
        for (int r = 0; r < vecs.size(); r++) begin
            vec_t v;
            v = vecs[r];
            start = v.start; cont = v.cont; err_clr = v.err_clr;
            ifc.s_valid = v.s_valid; ifc.s_data = v.s_data;
            ifc.res_en = v.res_en; ifc.res_data = v.res_data;
            step();
            chk("fft_en", ifc.fft_en, v.e_fen);
            chk("fft_addr", ifc.fft_addr, v.e_addr);
            if (v.e_fen) chk("fft_data", ifc.fft_data, v.e_fdata);
            chk("m_valid", ifc.m_valid, v.e_mv);
            if (v.e_mv) begin
                chk("m_data", ifc.m_data, v.e_md);
                chk("m_index", ifc.m_index, v.e_mi);
            end
            chk("frame_done", frame_done, v.e_fd);
            chk("busy", busy, v.e_busy);
            chk("s_ready", ifc.s_ready, v.e_sready);
            chk("err_underrun", err_underrun, v.e_under);
            chk("err_timeout", err_timeout, 0);
            $display("vec %0d: fft_en=%0b addr=%0d data=%0h m_valid=%0b idx=%0d done=%0b busy=%0b",
                     r, ifc.fft_en, ifc.fft_addr, ifc.fft_data, ifc.m_valid, ifc.m_index, frame_done, busy);
        end
        idle_inputs();

        // Continuous mode: 3 back-to-back frames, results streamed alongside; underrun set beats clear.
        start = 1'b1; cont = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cont = (i < 16);
            ifc.s_valid = (i != 10);
            ifc.s_data = i + 1;
            err_clr = (i == 10);
            ifc.res_en = 1'b1;
            ifc.res_data = 32'h300 + i;
            step();
            chk("cont_fft_en", ifc.fft_en, 1);
            chk("cont_fft_addr", ifc.fft_addr, i % 8);
            chk("cont_fft_data", ifc.fft_data, (i == 10) ? 0 : i + 1);
            chk("cont_m_index", ifc.m_index, i % 8);
            chk("cont_frame_done", frame_done, (i % 8) == 7);
            $display("cont %0d: addr=%0d data=%0h idx=%0d done=%0b", i, ifc.fft_addr, ifc.fft_data, ifc.m_index, frame_done);
        end
        idle_inputs();
        chk("cont_underrun_set_wins", err_underrun, 1);
        step();
        chk("cont_end_fft_en", ifc.fft_en, 0);
        chk("cont_end_fft_addr", ifc.fft_addr, 3'h7);
        for (int c = 0; c < 10 && busy; c++) step();
        chk("cont_idle", busy, 0);
        chk("cont_no_timeout", err_timeout, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("cont_underrun_cleared", err_underrun, 0);
        $display("cont sequence done: busy=%0b underrun=%0b", busy, err_underrun);

        // Drain timeout: frame issued but no results ever arrive.
        start = 1'b1;
        step();
        start = 1'b0;
        exit_c = -1;
        for (int c = 1; c <= 40; c++) begin
            ifc.s_valid = (c <= 8);
            ifc.s_data = 32'h40 + c;
            step();
            if (c == 23) begin
                chk("to_not_yet", err_timeout, 0);
                chk("to_busy_before", busy, 1);
            end
            if (!busy) begin
                exit_c = c;
                break;
            end
        end
        idle_inputs();
        chk("to_busy_cycles", exit_c, 24);
        chk("to_flag", err_timeout, 1);
        chk("to_idle", busy, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_cleared", err_timeout, 0);
        $display("timeout sequence: exit after %0d cycles", exit_c);

        // Reset in the middle of a frame, then restart from address 0.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            ifc.s_valid = 1'b1;
            ifc.s_data = 32'h60 + j;
            step();
        end
        chk("mid_addr", ifc.fft_addr, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fft_en", ifc.fft_en, 0);
        chk("mid_rst_fft_addr", ifc.fft_addr, 3'h7);
        chk("mid_rst_fft_data", ifc.fft_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", ifc.s_ready, 0);
        #2 rst_n = 1'b1;
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        ifc.s_valid = 1'b1;
        ifc.s_data = 32'h55;
        step();
        chk("restart_fft_en", ifc.fft_en, 1);
        chk("restart_fft_addr", ifc.fft_addr, 0);
        chk("restart_fft_data", ifc.fft_data, 32'h55);
        $display("reset sequence: restart addr=%0d data=%0h", ifc.fft_addr, ifc.fft_data);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_STAGE, default 8, meaning log2 of frame length N (N = 2^TOTAL_STAGE).
REQ-002 SHALL have parameter CPLX_WIDTH, default 32, meaning complex sample width ({re,im}).
REQ-003 SHALL have parameter DRAIN_MAX, default 1024, meaning DRAIN timeout in cycles.
REQ-004 SHALL have port iclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, frame-run request, sampled in IDLE.
REQ-007 SHALL have port cont, input, 1, continuous mode; sampled at each frame end.
REQ-008 SHALL have ports s_valid (input, 1), s_data (input, CPLX_WIDTH) and s_ready (output, 1), forming the sample source handshake.
REQ-009 SHALL have ports fft_en (output, 1), fft_addr (output, TOTAL_STAGE) and fft_data (output, CPLX_WIDTH), driving the first butterfly stage.
REQ-010 SHALL have ports res_en (input, 1) and res_data (input, CPLX_WIDTH), carrying the last-stage result stream.
REQ-011 SHALL have ports m_valid (output, 1), m_data (output, CPLX_WIDTH) and m_index (output, TOTAL_STAGE), forming the result stream with bin index.
REQ-012 SHALL have port busy, output, 1, high when not in IDLE.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse per N results.
REQ-014 SHALL have ports err_underrun (output, 1) and err_timeout (output, 1), sticky error flags.
REQ-015 SHALL have port err_clr, input, 1, synchronous clear of both error flags.

Function
REQ-016 SHALL implement states IDLE, FEED and DRAIN.
REQ-017 IDLE: s_ready=0 and fft_en=0; start=1 -> FEED with in_cnt=0.
REQ-018 FEED: s_ready=1 every cycle; each FEED cycle SHALL register fft_en=1, fft_addr=in_cnt and fft_data=s_data (1-cycle latency), then increment in_cnt.
REQ-019 FEED with s_valid=0 SHALL still issue fft_en=1 with fft_data=0 and set err_underrun, because stages need gap-free frames.
REQ-020 When in_cnt==N-1 is issued: cont=1 -> stay in FEED with in_cnt wrapping to 0, no idle cycle; cont=0 -> DRAIN.
REQ-021 DRAIN: fft_en=0 and s_ready=0; exit to IDLE when the result counter reaches frame end and no frame remains outstanding.
REQ-022 DRAIN with DRAIN_MAX cycles elapsed SHALL set err_timeout, go to IDLE and clear the outstanding-frame count.
REQ-023 fft_addr SHALL be driven to all-ones whenever fft_en=0.
REQ-024 Result path: on each res_en=1, register m_valid=1, m_data=res_data and m_index=out_cnt (1-cycle latency), then out_cnt++ modulo N.
REQ-025 When out_cnt wraps N-1 -> 0, frame_done SHALL pulse in the same cycle as m_valid for bin N-1.
REQ-026 SHALL keep a 4-bit outstanding-frame counter: increment on a frame fully issued, decrement on frame_done; simultaneous events leave it unchanged; it saturates at 15 and does not go below 0.
REQ-027 res_en arriving in IDLE SHALL still be forwarded; out_cnt counts regardless of state.
REQ-028 start during FEED or DRAIN SHALL be ignored.
REQ-029 err_clr and a same-cycle error set: set SHALL win.
REQ-030 busy SHALL be combinational, equal to (state != IDLE).

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, in_cnt=0, out_cnt=0 and outstanding=0.
REQ-032 During reset, outputs SHALL be: fft_en=0, fft_addr=all-ones, fft_data=0, m_valid=0, m_data=0, m_index=0, frame_done=0, errors=0 and s_ready=0.
REQ-033 Reset mid-FEED SHALL abandon the partial frame; the next start begins at address 0.

Verification (TOTAL_STAGE=3, N=8)
REQ-034 start pulse, cont=0, s_valid=1 with samples 1..8 -> fft_en high 8 cycles, fft_addr 0..7, fft_data 1..8 one cycle after acceptance, then DRAIN.
REQ-035 8 res_en pulses with data 0x10..0x17 -> m_index 0..7, frame_done on the 8th m_valid, then IDLE with busy=0.
REQ-036 cont=1 for 3 frames -> 24 contiguous fft_en cycles, fft_addr 0..7 repeated, no gap at the wraps.
REQ-037 s_valid=0 at addr 3 -> fft_en=1, fft_data=0 at addr 3 and err_underrun=1 until err_clr.
REQ-038 DRAIN_MAX=16 with no res_en after the frame -> err_timeout=1 at cycle 16 of DRAIN, then IDLE.
REQ-039 rst_n low at addr 5 -> outputs at reset values immediately; a new start gives fft_addr 0.
